// File: rtl/goto_rep_pkg.sv
// goto_rep_pkg: shared types and helpers for the goto/non-consecutive repetition checker.
// Optional timeout support is selected with GOTO_REP_CHECKER_TIMEOUT_EN.
package goto_rep_pkg;

    // Per-channel checker state
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCount   = 2'd1,
        StExpectC = 2'd2,
        StWaitC   = 2'd3
    } state_e;

    // GOTO: c exactly one cycle after the Nth b. NONCONSEC: c any later cycle, no further b.
    typedef enum logic {
        GOTO      = 1'b0,
        NONCONSEC = 1'b1
    } mode_e;

    // Failure cause reported alongside fail_o
    typedef enum logic [1:0] {
        FailNone    = 2'b00,
        FailNoC     = 2'b01,
        FailExtraB  = 2'b10,
        FailTimeout = 2'b11
    } fail_code_e;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/goto_rep_chan.sv
// goto_rep_chan: one monitored channel. Detects a rising edge on a_i, counts REP_COUNT b_i
// occurrences, then checks c_i according to MODE and emits registered one-cycle verdicts.
// With GOTO_REP_CHECKER_TIMEOUT_EN defined, a thread stuck in COUNT/WAIT_C for TIMEOUT_CYC
// cycles fails with the timeout code.
module goto_rep_chan
    import goto_rep_pkg::*;
#(
    parameter int unsigned REP_COUNT   = 3,
`ifdef GOTO_REP_CHECKER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 64,
`endif
    parameter mode_e       MODE        = GOTO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    output logic       pass_o,
    output logic       fail_o,
    output logic       fail_set_o,
    output logic       busy_o,
    output logic       overlap_o,
    output logic [1:0] fail_code_o
);

    localparam int unsigned CW     = cnt_width(REP_COUNT);
    localparam state_e      DoneSt = (MODE == GOTO) ? StExpectC : StWaitC;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_q;
    logic          trig;
    logic          timeout;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          ovl_q, ovl_d;
    fail_code_e    code_q, code_d;

    assign trig = a_i & ~a_q;

`ifdef GOTO_REP_CHECKER_TIMEOUT_EN
    localparam int unsigned TW = cnt_width(TIMEOUT_CYC);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          waiting;

    assign waiting = (state_q == StCount) || (state_q == StWaitC);
    assign timeout = waiting && (tmr_q == TW'(TIMEOUT_CYC - 1));

    // Elapsed timer: cleared while idle, runs through COUNT and WAIT_C, holds in EXPECT_C
    always_comb begin
        tmr_d = tmr_q;
        if (state_q == StIdle) begin
            tmr_d = '0;
        end else if (waiting) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Timer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, repetition count and verdict decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        ovl_d   = 1'b0;
        code_d  = FailNone;
        if (!en_i) begin
            // Disabled: drop any thread silently
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            // A trigger also lands here on the verdict cycle, since state is still non-idle
            ovl_d = trig && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        // b in the trigger cycle counts (overlapping implication)
                        if (b_i && (REP_COUNT == 1)) begin
                            state_d = DoneSt;
                        end else begin
                            state_d = StCount;
                            cnt_d   = b_i ? CW'(1) : '0;
                        end
                    end
                end
                StCount: begin
                    if (timeout) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        fail_d  = 1'b1;
                        code_d  = FailTimeout;
                    end else if (b_i) begin
                        if (cnt_q == CW'(REP_COUNT - 1)) begin
                            state_d = DoneSt;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                StExpectC: begin
                    state_d = StIdle;
                    if (c_i) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        code_d = FailNoC;
                    end
                end
                StWaitC: begin
                    // c wins over a simultaneous b
                    if (c_i) begin
                        state_d = StIdle;
                        pass_d  = 1'b1;
                    end else if (b_i) begin
                        state_d = StIdle;
                        fail_d  = 1'b1;
                        code_d  = FailExtraB;
                    end else if (timeout) begin
                        state_d = StIdle;
                        fail_d  = 1'b1;
                        code_d  = FailTimeout;
                    end
                end
            endcase
        end
    end

    // State, count and registered verdict outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ovl_q   <= 1'b0;
            code_q  <= FailNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_i;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ovl_q   <= ovl_d;
            code_q  <= code_d;
        end
    end

    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign fail_set_o  = fail_d;
    assign overlap_o   = ovl_q;
    assign fail_code_o = code_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: rtl/goto_rep_checker.sv
// goto_rep_checker: CHANNELS independent repetition checkers plus a saturating total of
// reported failures. Timeout support is enabled by defining GOTO_REP_CHECKER_TIMEOUT_EN.
module goto_rep_checker
    import goto_rep_pkg::*;
#(
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned REP_COUNT   = 3,
    parameter mode_e       MODE        = GOTO,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [CHANNELS-1:0]   a_i,
    input  logic [CHANNELS-1:0]   b_i,
    input  logic [CHANNELS-1:0]   c_i,
    output logic [CHANNELS-1:0]   pass_o,
    output logic [CHANNELS-1:0]   fail_o,
    output logic [CHANNELS-1:0]   busy_o,
    output logic [CHANNELS-1:0]   overlap_o,
    output logic [2*CHANNELS-1:0] fail_code_o,
    output logic [15:0]           err_count_o
);

    if (CHANNELS < 1 || CHANNELS > 8 || REP_COUNT < 1 || REP_COUNT > 255 ||
        TIMEOUT_CYC < 1) begin : g_param_err
        $error("goto_rep_checker: parameter out of range");
    end

    logic [CHANNELS-1:0] fail_set;
    logic [3:0]          n_fail;
    logic [16:0]         err_sum;
    logic [15:0]         err_q, err_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        goto_rep_chan #(
            .REP_COUNT   (REP_COUNT),
`ifdef GOTO_REP_CHECKER_TIMEOUT_EN
            .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
            .MODE        (MODE)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_i        (en_i),
            .a_i         (a_i[i]),
            .b_i         (b_i[i]),
            .c_i         (c_i[i]),
            .pass_o      (pass_o[i]),
            .fail_o      (fail_o[i]),
            .fail_set_o  (fail_set[i]),
            .busy_o      (busy_o[i]),
            .overlap_o   (overlap_o[i]),
            .fail_code_o (fail_code_o[2*i +: 2])
        );
    end

    // Add this cycle's new failures so the total moves together with fail_o; saturate
    always_comb begin
        n_fail = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_fail = n_fail + 4'(fail_set[i]);
        end
        err_sum = {1'b0, err_q} + 17'(n_fail);
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Failure total register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count_o = err_q;

endmodule

// File: tb/tb_goto_rep_checker.sv
// Bench for goto_rep_checker: two instances (GOTO N=3, NONCONSEC N=2, four channels each)
// share stimulus; a thread-level reference model predicts every output cycle into scoreboards.
module tb_goto_rep_checker;
    import goto_rep_pkg::*;

    localparam int TO = 10;
`ifdef GOTO_REP_CHECKER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0;

    logic [3:0]  pass0, fail0, busy0, ovl0, pass1, fail1, busy1, ovl1;
    logic [7:0]  code0, code1;
    logic [15:0] err0, err1;

    typedef struct packed {
        logic [3:0]  pass;
        logic [3:0]  fail;
        logic [3:0]  ovl;
        logic [3:0]  busy;
        logic [7:0]  code;
        logic [15:0] err;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: per dut, per channel thread bookkeeping
    bit act[2][4];
    bit rdy[2][4];
    int nb[2][4];
    int el[2][4];
    bit ap[2][4];
    int errc[2];

    always #5 clk = ~clk;

    goto_rep_checker #(
        .CHANNELS (4), .REP_COUNT (3), .MODE (GOTO), .TIMEOUT_CYC (TO)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n), .en_i (en), .a_i (a), .b_i (b), .c_i (c),
        .pass_o (pass0), .fail_o (fail0), .busy_o (busy0), .overlap_o (ovl0),
        .fail_code_o (code0), .err_count_o (err0)
    );

    goto_rep_checker #(
        .CHANNELS (4), .REP_COUNT (2), .MODE (NONCONSEC), .TIMEOUT_CYC (TO)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n), .en_i (en), .a_i (a), .b_i (b), .c_i (c),
        .pass_o (pass1), .fail_o (fail1), .busy_o (busy1), .overlap_o (ovl1),
        .fail_code_o (code1), .err_count_o (err1)
    );

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            errc[d] = 0;
            for (int i = 0; i < 4; i++) begin
                act[d][i] = 0; rdy[d][i] = 0; nb[d][i] = 0; el[d][i] = 0; ap[d][i] = 0;
            end
        end
    endtask

    // One sampled cycle of thread behaviour; e holds the outputs visible after the edge
    task automatic model_step(input int d, input logic e_en, input logic [3:0] av,
                              input logic [3:0] bv, input logic [3:0] cv, output exp_t e);
        int n;
        bit go;
        bit trig;
        int nf;
        n  = (d == 0) ? 3 : 2;
        go = (d == 0);
        nf = 0;
        e  = '0;
        for (int i = 0; i < 4; i++) begin
            trig      = av[i] && !ap[d][i];
            ap[d][i]  = av[i];
            if (!e_en) begin
                act[d][i] = 0;
            end else if (act[d][i]) begin
                e.ovl[i] = trig;
                if (rdy[d][i] && (go || cv[i])) begin
                    act[d][i] = 0;
                    if (cv[i]) e.pass[i] = 1'b1;
                    else begin e.fail[i] = 1'b1; e.code[2*i +: 2] = 2'd1; end
                end else if (rdy[d][i] && bv[i]) begin
                    act[d][i] = 0;
                    e.fail[i] = 1'b1;
                    e.code[2*i +: 2] = 2'd2;
                end else begin
                    if (!rdy[d][i] && bv[i]) nb[d][i]++;
                    el[d][i]++;
                    if (TmoEn && el[d][i] == TO) begin
                        act[d][i] = 0;
                        e.fail[i] = 1'b1;
                        e.code[2*i +: 2] = 2'd3;
                    end else if (nb[d][i] == n) begin
                        rdy[d][i] = 1;
                    end
                end
            end else if (trig) begin
                act[d][i] = 1;
                nb[d][i]  = bv[i] ? 1 : 0;
                rdy[d][i] = (nb[d][i] == n);
                el[d][i]  = 0;
            end
            e.busy[i] = act[d][i];
            nf += int'(e.fail[i]);
        end
        errc[d] = (errc[d] + nf > 65535) ? 65535 : errc[d] + nf;
        e.err   = 16'(errc[d]);
    endtask

    task automatic apply(input logic e_en, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] cv);
        exp_t x0, x1;
        en = e_en; a = av; b = bv; c = cv;
        model_step(0, e_en, av, bv, cv, x0);
        model_step(1, e_en, av, bv, cv, x1);
        sb0.push_back(x0);
        sb1.push_back(x1);
    endtask

    task automatic cycle(input logic e_en, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] cv);
        @(negedge clk);
        apply(e_en, av, bv, cv);
    endtask

    // Timeline on one channel: bit k of each mask is that input's value in cycle k
    task automatic seq(input int ch, input logic [31:0] am, input logic [31:0] bm,
                       input logic [31:0] cm, input int len);
        logic [3:0] one;
        one = 4'b0001 << ch;
        for (int k = 0; k < len; k++) begin
            cycle(1'b1, am[k] ? one : 4'b0, bm[k] ? one : 4'b0, cm[k] ? one : 4'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pass0"}, 32'(pass0), 0);
        chk({tag, "_fail0"}, 32'(fail0), 0);
        chk({tag, "_busy0"}, 32'(busy0), 0);
        chk({tag, "_ovl0"},  32'(ovl0),  0);
        chk({tag, "_code0"}, 32'(code0), 0);
        chk({tag, "_err0"},  32'(err0),  0);
        chk({tag, "_pass1"}, 32'(pass1), 0);
        chk({tag, "_fail1"}, 32'(fail1), 0);
        chk({tag, "_busy1"}, 32'(busy1), 0);
        chk({tag, "_ovl1"},  32'(ovl1),  0);
        chk({tag, "_code1"}, 32'(code1), 0);
        chk({tag, "_err1"},  32'(err1),  0);
    endtask

    // Monitor: every predicted cycle is compared against both instances
    initial begin
        exp_t x0, x1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb0.size() > 0 && sb1.size() > 0) begin
                x0 = sb0.pop_front();
                x1 = sb1.pop_front();
                chk("d0_pass", 32'(pass0), 32'(x0.pass));
                chk("d0_fail", 32'(fail0), 32'(x0.fail));
                chk("d0_code", 32'(code0), 32'(x0.code));
                chk("d0_busy", 32'(busy0), 32'(x0.busy));
                chk("d0_ovl",  32'(ovl0),  32'(x0.ovl));
                chk("d0_err",  32'(err0),  32'(x0.err));
                chk("d1_pass", 32'(pass1), 32'(x1.pass));
                chk("d1_fail", 32'(fail1), 32'(x1.fail));
                chk("d1_code", 32'(code1), 32'(x1.code));
                chk("d1_busy", 32'(busy1), 32'(x1.busy));
                chk("d1_ovl",  32'(ovl1),  32'(x1.ovl));
                chk("d1_err",  32'(err1),  32'(x1.err));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 4'b0, 4'b0, 4'b0);

        // GOTO pass: a rises at 2, b at 3,5,7, c at 8
        seq(0, 32'h1C, 32'hA8, 32'h100, 14);
        // GOTO missing c: c only at 9
        seq(0, 32'h1C, 32'hA8, 32'h200, 14);
        @(negedge clk);
        chk("d0_err_after_no_c", 32'(err0), 32'd1);
        apply(1'b1, 4'b0, 4'b0, 4'b0);
        // NONCONSEC pass with b at 3,4 and c at 8; then extra b at 6
        seq(0, 32'h1C, 32'h18, 32'h100, 12);
        seq(0, 32'h1C, 32'h58, 32'h000, 12);
        // Retrigger while busy on channel 1
        seq(1, 32'h24, 32'hA8, 32'h100, 14);

        // Asynchronous reset mid-count on channel 2
        seq(2, 32'h1C, 32'h18, 32'h000, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        sb0.delete();
        sb1.delete();
        model_reset();
        a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 4'b0100, 4'b0, 4'b0);
        seq(2, 32'h03, 32'h0E, 32'h10, 8);

        // Enable dropped mid-count on channel 3, then a late c must not produce a verdict
        seq(3, 32'h1C, 32'h08, 32'h000, 5);
        cycle(1'b0, 4'b0, 4'b0, 4'b0);
        seq(3, 32'h00, 32'h00, 32'h06, 6);

`ifdef GOTO_REP_CHECKER_TIMEOUT_EN
        // Trigger with a single b, then silence until timeout
        seq(0, 32'h04, 32'h08, 32'h0, 16);
`endif

        // Randomised traffic on all channels
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] ar, br, cr;
            ar = 4'($urandom());
            br = 4'($urandom());
            cr = 4'($urandom() & $urandom());
            cycle($urandom_range(0, 99) != 0, ar, br, cr);
        end
        cycle(1'b1, 4'b0, 4'b0, 4'b0);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
